tug_of_war_core: RTL and testbench
==================================

Name: tug_of_war_core

Overview:
Parametrised successor to the single-round tug-of-war game. It tracks the rope position across NUM_LIGHTS lights and detects round winners. It keeps per-player round scores and declares a match winner at WIN_ROUNDS. Sits between the doubleFlip-synchronised key inputs and the LEDR/HEX display drivers in DE1_SoC.

Parameters:
NUM_LIGHTS, 9, number of rope lights; must be odd and at least 3; centre index CENTER = (NUM_LIGHTS-1)/2
WIN_ROUNDS, 7, rounds needed to win the match; at least 1
HOLD_CYCLES, 50000000, cycles the finished-round display is frozen before recentering; at least 1
SCORE_W, $clog2(WIN_ROUNDS+1), score counter width (derived)

Ports:
clk  input  1  system clock (50 MHz on board)
reset  input  1  asynchronous, active-low reset
press_l  input  1  synchronised level, high while the left key is held
press_r  input  1  synchronised level, high while the right key is held
new_game  input  1  synchronous, single-cycle; clears scores and recentres
lights  output  NUM_LIGHTS  one-hot rope position; bit NUM_LIGHTS-1 is leftmost
score_l  output  SCORE_W  rounds won by the left player
score_r  output  SCORE_W  rounds won by the right player
round_winner  output  2  winner_t: NONE=0, LEFT=1, RIGHT=2; valid in HOLD and MATCH_OVER
match_over  output  1  high in MATCH_OVER
match_winner  output  2  winner_t; NONE unless match_over

Behaviour:
- Reset (reset=0, async): state=PLAY, pos=CENTER, lights=1<<CENTER, scores=0, round_winner=NONE, match_over=0, match_winner=NONE, edge-detect history=0, hold counter=0.
- Edge detect: each press counts once. ev_l = press_l & ~press_l_q (same for right). History registers update every cycle in every state.
- Simultaneous ev_l and ev_r in the same cycle cancel; no move.
- PLAY:
  - ev_l only: if pos==NUM_LIGHTS-1, left wins the round; else pos+1.
  - ev_r only: if pos==0, right wins the round; else pos-1.
  - lights update the cycle after the event (1-cycle latency).
- Round win:
  - winner score +1 in the same cycle. Scores saturate at WIN_ROUNDS and never wrap.
  - round_winner is set and lights stay on the edge light.
  - If the new score == WIN_ROUNDS, go to MATCH_OVER and set match_winner. Otherwise go to HOLD with counter=0.
- HOLD: all presses are ignored. The counter increments each cycle. When counter==HOLD_CYCLES-1: pos=CENTER, round_winner=NONE, go to PLAY. Total freeze is exactly HOLD_CYCLES cycles.
- MATCH_OVER: presses are ignored and all outputs hold. Only new_game or reset exits.
- new_game, any state: next cycle pos=CENTER, scores=0, winners=NONE, match_over=0, state=PLAY. It overrides any press event in the same cycle.
- Reset mid-HOLD or mid-press: the async clear takes effect immediately. A key still held on release of reset does not generate an event.
- lights is always exactly one-hot.

Optional Feature:
COMPUTER_PLAYER_EN
- Defined:
  - Adds input cpu_level[3:0] and parameter CPU_DIV (default 5000000).
  - A prescaler wraps every CPU_DIV cycles; a 10-bit LFSR (x^10+x^7+1, seed 10'h1, reset to seed) steps on each wrap.
  - A right-player event is generated on a wrap cycle when lfsr[3:0] < cpu_level. press_r is ignored.
  - cpu_level=0 means the computer never presses.
- Undefined: no extra port; press_r drives the right player as described above.

Decomposition:
- Package tug_pkg holds winner_t (NONE/LEFT/RIGHT, 2 bits), state_t (PLAY/HOLD/MATCH_OVER), and LFSR_SEED/LFSR_TAPS.
- One sub-module, press_edge: clk, reset, level in, 1-cycle pulse out. It is instantiated twice.
- The FSM, position counter and scores stay in the top module.

Test Plan:
All scenarios use NUM_LIGHTS=9, WIN_ROUNDS=2, HOLD_CYCLES=4, macro undefined.
- Reset, then hold press_l high for 10 cycles -> exactly one move; lights=9'b000100000, pos=5.
- Five separate press_l pulses from centre -> lights=9'b100000000 after four; the fifth gives score_l=1, round_winner=LEFT. After 4 frozen cycles lights=9'b000010000 and round_winner=NONE.
- press_l and press_r rising in the same cycle, 3 times -> lights unchanged at 9'b000010000.
- Right player wins two rounds -> score_r=2, match_over=1, match_winner=RIGHT. Further presses leave all outputs unchanged. new_game gives scores 0, lights centred and match_over=0 next cycle.
- press_l events during HOLD -> ignored; pos=CENTER on exit and score_l unchanged.
- Assert reset mid-HOLD, then release with press_l held -> outputs at reset values immediately; no move until press_l falls and rises again.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war core: winner/state encodings
// and the computer-player LFSR constants.
package tug_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } winner_t;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  // x^10 + x^7 + 1: feedback from bits 9 and 6 of a left-shifting register
  localparam logic [9:0] LFSR_SEED = 10'h001;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/tug_of_war_core_press_edge.sv
// Rising-edge detector for one synchronised key level; a key already held
// when reset is released is not reported until it is released and pressed again.
module press_edge
  import tug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_q;
  logic r_armed;

  // Level history plus a one-shot arm flag that masks the first cycle after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q     <= i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_pulse = i_level & ~r_q & r_armed;

endmodule

// File: rtl/tug_of_war_core.sv
// Tug-of-war game core: rope position, round detection, scores and match winner.
// Optional macro COMPUTER_PLAYER_EN replaces the right key with an LFSR-driven player.
module tug_of_war_core
  import tug_pkg::*;
#(
`ifdef COMPUTER_PLAYER_EN
  parameter int CPU_DIV     = 5000000,
`endif
  parameter int NUM_LIGHTS  = 9,
  parameter int WIN_ROUNDS  = 7,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCORE_W     = $clog2(WIN_ROUNDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  press_l,
  input  logic                  press_r,
  input  logic                  new_game,
`ifdef COMPUTER_PLAYER_EN
  input  logic [3:0]            cpu_level,
`endif
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic [1:0]            round_winner,
  output logic                  match_over,
  output logic [1:0]            match_winner
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0]      POS_LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0]      POS_CENTER = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(WIN_ROUNDS);
  localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE = NUM_LIGHTS'(1);

  logic w_ev_l;
  logic w_edge_r;
  logic w_ev_r;

  press_edge u_edge_l (.clk(clk), .reset(reset), .i_level(press_l), .o_pulse(w_ev_l));
  press_edge u_edge_r (.clk(clk), .reset(reset), .i_level(press_r), .o_pulse(w_edge_r));

`ifdef COMPUTER_PLAYER_EN
  localparam int DW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  logic [DW-1:0] r_div;
  logic [9:0]    r_lfsr;
  logic          w_wrap;

  assign w_wrap = (r_div == DW'(CPU_DIV - 1));

  // Prescaler and LFSR pacing the computer's attempts to press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_lfsr <= {r_lfsr[8:0], ^(r_lfsr & LFSR_TAPS)};
    end else begin
      r_div  <= r_div + DW'(1);
      r_lfsr <= r_lfsr;
    end
  end

  assign w_ev_r = w_wrap & (r_lfsr[3:0] < cpu_level);
`else
  assign w_ev_r = w_edge_r;
`endif

  state_t                r_state,   w_state_nx;
  logic [PW-1:0]         r_pos,     w_pos_nx;
  logic [NUM_LIGHTS-1:0] r_lights,  w_lights_nx;
  logic [SCORE_W-1:0]    r_score_l, w_score_l_nx;
  logic [SCORE_W-1:0]    r_score_r, w_score_r_nx;
  winner_t               r_rwin,    w_rwin_nx;
  winner_t               r_mwin,    w_mwin_nx;
  logic                  r_mover,   w_mover_nx;
  logic [HW-1:0]         r_hold,    w_hold_nx;

  // Next-state: new_game has priority; PLAY moves the rope, HOLD freezes, MATCH_OVER latches
  always_comb begin
    w_state_nx   = r_state;
    w_pos_nx     = r_pos;
    w_score_l_nx = r_score_l;
    w_score_r_nx = r_score_r;
    w_rwin_nx    = r_rwin;
    w_mwin_nx    = r_mwin;
    w_mover_nx   = r_mover;
    w_hold_nx    = r_hold;
    if (new_game) begin
      w_state_nx   = PLAY;
      w_pos_nx     = POS_CENTER;
      w_score_l_nx = '0;
      w_score_r_nx = '0;
      w_rwin_nx    = NONE;
      w_mwin_nx    = NONE;
      w_mover_nx   = 1'b0;
      w_hold_nx    = '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_ev_l && !w_ev_r) begin
            if (r_pos == POS_LAST) begin
              w_score_l_nx = (r_score_l == SCORE_MAX) ? r_score_l : r_score_l + SCORE_W'(1);
              w_rwin_nx    = LEFT;
              w_hold_nx    = '0;
              if (w_score_l_nx == SCORE_MAX) begin
                w_state_nx = MATCH_OVER;
                w_mwin_nx  = LEFT;
                w_mover_nx = 1'b1;
              end else begin
                w_state_nx = HOLD;
              end
            end else begin
              w_pos_nx = r_pos + PW'(1);
            end
          end else if (w_ev_r && !w_ev_l) begin
            if (r_pos == '0) begin
              w_score_r_nx = (r_score_r == SCORE_MAX) ? r_score_r : r_score_r + SCORE_W'(1);
              w_rwin_nx    = RIGHT;
              w_hold_nx    = '0;
              if (w_score_r_nx == SCORE_MAX) begin
                w_state_nx = MATCH_OVER;
                w_mwin_nx  = RIGHT;
                w_mover_nx = 1'b1;
              end else begin
                w_state_nx = HOLD;
              end
            end else begin
              w_pos_nx = r_pos - PW'(1);
            end
          end else begin
            w_pos_nx = r_pos;
          end
        end
        HOLD: begin
          if (r_hold == HOLD_LAST) begin
            w_state_nx = PLAY;
            w_pos_nx   = POS_CENTER;
            w_rwin_nx  = NONE;
            w_hold_nx  = '0;
          end else begin
            w_hold_nx = r_hold + HW'(1);
          end
        end
        MATCH_OVER: begin
          w_state_nx = MATCH_OVER;
        end
        default: begin
          w_state_nx = PLAY;
          w_pos_nx   = POS_CENTER;
        end
      endcase
    end
    w_lights_nx = LIGHT_ONE << w_pos_nx;
  end

  // Game state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= PLAY;
      r_pos     <= POS_CENTER;
      r_lights  <= LIGHT_ONE << POS_CENTER;
      r_score_l <= '0;
      r_score_r <= '0;
      r_rwin    <= NONE;
      r_mwin    <= NONE;
      r_mover   <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pos     <= w_pos_nx;
      r_lights  <= w_lights_nx;
      r_score_l <= w_score_l_nx;
      r_score_r <= w_score_r_nx;
      r_rwin    <= w_rwin_nx;
      r_mwin    <= w_mwin_nx;
      r_mover   <= w_mover_nx;
      r_hold    <= w_hold_nx;
    end
  end

  assign lights       = r_lights;
  assign score_l      = r_score_l;
  assign score_r      = r_score_r;
  assign round_winner = r_rwin;
  assign match_over   = r_mover;
  assign match_winner = r_mwin;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Directed self-checking bench for tug_of_war_core with NUM_LIGHTS=9,
// WIN_ROUNDS=2, HOLD_CYCLES=4 and the computer player disabled.
module tb_tug_of_war_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       press_l = 1'b0;
  logic       press_r = 1'b0;
  logic       new_game = 1'b0;
  logic [8:0] lights;
  logic [1:0] score_l;
  logic [1:0] score_r;
  logic [1:0] round_winner;
  logic       match_over;
  logic [1:0] match_winner;

  int checks = 0;
  int errors = 0;

  tug_of_war_core #(
    .NUM_LIGHTS (9),
    .WIN_ROUNDS (2),
    .HOLD_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .press_l     (press_l),
    .press_r     (press_r),
    .new_game    (new_game),
    .lights      (lights),
    .score_l     (score_l),
    .score_r     (score_r),
    .round_winner(round_winner),
    .match_over  (match_over),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_l();
    press_l = 1'b1;
    tick();
    press_l = 1'b0;
    tick();
  endtask

  task automatic pulse_r();
    press_r = 1'b1;
    tick();
    press_r = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input logic [8:0] l, input logic [1:0] sl,
                           input logic [1:0] sr, input logic [1:0] rw, input logic mo,
                           input logic [1:0] mw);
    check({tag, "_lights"}, 32'(lights), 32'(l));
    check({tag, "_score_l"}, 32'(score_l), 32'(sl));
    check({tag, "_score_r"}, 32'(score_r), 32'(sr));
    check({tag, "_round_winner"}, 32'(round_winner), 32'(rw));
    check({tag, "_match_over"}, 32'(match_over), 32'(mo));
    check({tag, "_match_winner"}, 32'(match_winner), 32'(mw));
  endtask

  initial begin
    // Reset state while reset is asserted
    #12;
    check_all("reset", 9'b000010000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Held key moves exactly once
    press_l = 1'b1;
    repeat (10) tick();
    check("held_once", 32'(lights), 32'(9'b000100000));
    press_l = 1'b0;
    tick();

    // Recentre, then walk left to the edge
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("recentre", 32'(lights), 32'(9'b000010000));
    pulse_l();
    check("step1", 32'(lights), 32'(9'b000100000));
    repeat (3) pulse_l();
    check_all("left_edge", 9'b100000000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);

    // Fifth press wins the round; presses during HOLD are ignored
    press_l = 1'b1;
    tick();
    check_all("left_win", 9'b100000000, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0);
    press_l = 1'b0;
    tick();
    press_l = 1'b1;
    tick();
    press_l = 1'b0;
    tick();
    check_all("hold_frozen", 9'b100000000, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0);
    press_l = 1'b1;
    tick();
    press_l = 1'b0;
    check_all("hold_exit", 9'b000010000, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    check("after_hold_still", 32'(lights), 32'(9'b000010000));

    // Simultaneous presses cancel
    repeat (3) begin
      press_l = 1'b1;
      press_r = 1'b1;
      tick();
      press_l = 1'b0;
      press_r = 1'b0;
      tick();
    end
    check("simul_cancel", 32'(lights), 32'(9'b000010000));

    // Right wins round one
    repeat (4) pulse_r();
    check("right_edge", 32'(lights), 32'(9'b000000001));
    pulse_r();
    check_all("right_win1", 9'b000000001, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0);
    repeat (3) tick();
    check_all("right_hold_exit", 9'b000010000, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0);

    // Right wins round two and the match
    repeat (5) pulse_r();
    check_all("match", 9'b000000001, 2'd1, 2'd2, 2'd2, 1'b1, 2'd2);
    pulse_l();
    pulse_l();
    pulse_r();
    check_all("match_frozen", 9'b000000001, 2'd1, 2'd2, 2'd2, 1'b1, 2'd2);

    // new_game overrides a same-cycle press
    new_game = 1'b1;
    press_l = 1'b1;
    tick();
    new_game = 1'b0;
    press_l = 1'b0;
    check_all("new_game", 9'b000010000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();

    // Win a round, then reset mid-HOLD with the left key held
    repeat (5) pulse_l();
    check("pre_reset_hold", 32'(round_winner), 32'(2'd1));
    press_l = 1'b1;
    reset = 1'b0;
    #1;
    check_all("async_reset", 9'b000010000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("held_through_reset", 32'(lights), 32'(9'b000010000));
    press_l = 1'b0;
    tick();
    press_l = 1'b1;
    tick();
    check("repress_moves", 32'(lights), 32'(9'b000100000));
    press_l = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
